loop_filter: RTL and testbench

//  Digital proportional-integral loop filter of the ADPLL. It sits directly downstream of the

---
 rtl/loop_filter.sv | 190 +++++++++++++++++++
 tb/tb_loop_filter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/loop_filter.sv
// Proportional-integral loop filter for the ADPLL: turns the strobed phase
// error into the DCO control word and owns acquire/track gain scheduling.
module loop_filter #(
  parameter int unsigned ERR_W         = 8,
  parameter int unsigned INT_W         = 20,
  parameter int unsigned FRAC_W        = 8,
  parameter int unsigned CTRL_W        = 10,
  parameter int unsigned CTRL_CENTRE   = 512,
  parameter int unsigned ACQ_BOOST     = 2,
  parameter int unsigned LOCK_THRESH   = 4,
  parameter int unsigned UNLOCK_THRESH = 16,
  parameter int unsigned LOCK_COUNT    = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic signed [ERR_W-1:0] error_i,
  input  logic                    error_valid_i,
  input  logic [2:0]              kp_shift_i,
  input  logic [2:0]              ki_shift_i,
  input  logic                    freeze_i,
  output logic [CTRL_W-1:0]       ctrl_o,
  output logic                    ctrl_valid_o,
  output logic                    sat_o,
  output logic                    lock_o
);

  localparam int unsigned SUM_W = INT_W + 1;
  localparam int unsigned OUT_W = SUM_W + 1;
  localparam int unsigned ABS_W = ERR_W + 1;
  localparam int unsigned CNT_W = $clog2(LOCK_COUNT + 1);

  localparam logic signed [SUM_W-1:0] INT_MAX  = SUM_W'((64'd1 << (INT_W - 1)) - 64'd1);
  localparam logic signed [SUM_W-1:0] INT_MIN  = -INT_MAX;
  localparam logic signed [OUT_W-1:0] CENTRE   = OUT_W'(CTRL_CENTRE);
  localparam logic signed [OUT_W-1:0] CTRL_MAX = OUT_W'((64'd1 << CTRL_W) - 64'd1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic signed [INT_W-1:0] integ_q, prop_q;
  logic                    isat_q, v1_q;

  logic [3:0]              boost, kp_eff, ki_eff;
  logic signed [INT_W-1:0] err_ext, prop_c, inc_c, integ_c;
  logic signed [SUM_W-1:0] sum_c;
  logic                    isat_c;

  logic signed [ABS_W-1:0] err_sx;
  logic [ABS_W-1:0]        err_abs;
  logic                    in_lock, over_unlock;

  logic signed [SUM_W-1:0] tot_c, s_c;
  logic signed [OUT_W-1:0] out_c;
  logic [CTRL_W-1:0]       ctrl_c;
  logic                    osat_c;

  // Effective gains: boosted during IDLE/ACQUIRE, nominal in TRACK
  always_comb begin
    boost  = (state_q == TRACK) ? 4'd0 : 4'(ACQ_BOOST);
    kp_eff = 4'(kp_shift_i) + boost;
    ki_eff = 4'(ki_shift_i) + boost;
  end

  // Stage-1 arithmetic: proportional term and clamped integrator update
  always_comb begin
    err_ext = {{(INT_W - ERR_W){error_i[ERR_W-1]}}, error_i};
    prop_c  = err_ext <<< kp_eff;
    inc_c   = err_ext <<< ki_eff;
    sum_c   = {integ_q[INT_W-1], integ_q} + {inc_c[INT_W-1], inc_c};
    integ_c = integ_q;
    isat_c  = 1'b0;
    if (!freeze_i) begin
      if (sum_c > INT_MAX) begin
        integ_c = INT_MAX[INT_W-1:0];
        isat_c  = 1'b1;
      end else if (sum_c < INT_MIN) begin
        integ_c = INT_MIN[INT_W-1:0];
        isat_c  = 1'b1;
      end else begin
        integ_c = sum_c[INT_W-1:0];
      end
    end
  end

  // Error magnitude one bit wider so that the most negative input is exact
  always_comb begin
    err_sx      = {error_i[ERR_W-1], error_i};
    err_abs     = err_sx[ABS_W-1] ? -err_sx : err_sx;
    in_lock     = (err_abs <= ABS_W'(LOCK_THRESH));
    over_unlock = (err_abs > ABS_W'(UNLOCK_THRESH));
  end

  // Lock FSM next state, advanced only on accepted samples
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (error_valid_i) begin
      case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          cnt_d   = in_lock ? CNT_W'(1) : '0;
        end
        ACQUIRE: begin
          if (!in_lock) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(LOCK_COUNT - 1)) begin
            state_d = TRACK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        TRACK: begin
          if (over_unlock) begin
            state_d = ACQUIRE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Stage-2 arithmetic: floor-scale the accumulator and clamp around centre
  always_comb begin
    tot_c  = {integ_q[INT_W-1], integ_q} + {prop_q[INT_W-1], prop_q};
    s_c    = tot_c >>> FRAC_W;
    out_c  = {s_c[SUM_W-1], s_c} + CENTRE;
    ctrl_c = out_c[CTRL_W-1:0];
    osat_c = 1'b0;
    if (out_c[OUT_W-1]) begin
      ctrl_c = '0;
      osat_c = 1'b1;
    end else if (out_c > CTRL_MAX) begin
      ctrl_c = '1;
      osat_c = 1'b1;
    end
  end

  // FSM state, lock counter and lock flag registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lock_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lock_o  <= (state_d == TRACK);
    end
  end

  // Stage-1 registers: capture prop/integ on each accepted sample
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prop_q  <= '0;
      integ_q <= '0;
      isat_q  <= 1'b0;
      v1_q    <= 1'b0;
    end else begin
      v1_q <= error_valid_i;
      if (error_valid_i) begin
        prop_q  <= prop_c;
        integ_q <= integ_c;
        isat_q  <= isat_c;
      end
    end
  end

  // Stage-2 registers: control word, saturation flag and update strobe
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ctrl_o       <= CTRL_W'(CTRL_CENTRE);
      ctrl_valid_o <= 1'b0;
      sat_o        <= 1'b0;
    end else begin
      ctrl_valid_o <= v1_q;
      if (v1_q) begin
        ctrl_o <= ctrl_c;
        sat_o  <= isat_q | osat_c;
      end
    end
  end

endmodule

// File: tb/tb_loop_filter.sv
// Bench for loop_filter: vector table plus scoreboard of expected control words.
module tb_loop_filter;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic signed [7:0] error_i;
  logic              error_valid_i;
  logic [2:0]        kp_shift_i;
  logic [2:0]        ki_shift_i;
  logic              freeze_i;
  logic [9:0]        ctrl_o;
  logic              ctrl_valid_o;
  logic              sat_o;
  logic              lock_o;

  loop_filter dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .error_i       (error_i),
    .error_valid_i (error_valid_i),
    .kp_shift_i    (kp_shift_i),
    .ki_shift_i    (ki_shift_i),
    .freeze_i      (freeze_i),
    .ctrl_o        (ctrl_o),
    .ctrl_valid_o  (ctrl_valid_o),
    .sat_o         (sat_o),
    .lock_o        (lock_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit rst;
    int err;
    int kp;
    int ki;
    bit frz;
    int ctrl;
    bit sat;
    bit lock;
  } vec_t;

  typedef struct {
    int ctrl;
    bit sat;
    int idx;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(bit rst, int err, int kp, int ki, bit frz,
                              int ctrl, bit sat, bit lock);
    vec_t v;
    v.rst = rst; v.err = err; v.kp = kp; v.ki = ki; v.frz = frz;
    v.ctrl = ctrl; v.sat = sat; v.lock = lock;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // One clock; sample after the edge and retire any control-word update
  task automatic tick();
    exp_t e;
    @(posedge clk_i);
    #1;
    if (ctrl_valid_o) begin
      if (sb.size() == 0) begin
        check("unexpected ctrl_valid_o", 1, 0);
      end else begin
        e = sb.pop_front();
        check($sformatf("ctrl_o[%0d]", e.idx), int'(ctrl_o), e.ctrl);
        check($sformatf("sat_o[%0d]", e.idx), int'(sat_o), int'(e.sat));
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset_i       = 1'b1;
    error_valid_i = 1'b0;
    freeze_i      = 1'b0;
    sb.delete();
    repeat (n) tick();
    reset_i = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 6 && sb.size() != 0; k++) tick();
    check("scoreboard drained", sb.size(), 0);
  endtask

  initial begin
    exp_t e;
    reset_i       = 1'b1;
    error_i       = '0;
    error_valid_i = 1'b0;
    kp_shift_i    = '0;
    ki_shift_i    = '0;
    freeze_i      = 1'b0;

    // rst, err, kp, ki, frz, ctrl, sat, lock
    // Freeze and floor rounding with negative errors
    add(1, -128, 0, 0, 0, 508, 0, 0);
    add(0, -128, 0, 0, 1, 508, 0, 0);
    add(0, -128, 0, 0, 0, 506, 0, 0);
    add(0,    0, 0, 0, 0, 508, 0, 0);
    add(0,   -1, 0, 0, 0, 507, 0, 0);
    // Lock acquisition, TRACK gain, unlock at 17, restart after |e|=5
    add(1, 2, 0, 0, 0, 512, 0, 0);
    for (int k = 0; k < 6; k++) add(0, 2, 0, 0, 0, 512, 0, 0);
    add(0,  2, 0, 0, 0, 512, 0, 1);
    add(0, 16, 7, 0, 0, 520, 0, 1);
    add(0, 17, 0, 0, 0, 512, 0, 0);
    add(0,  2, 0, 0, 0, 512, 0, 0);
    add(0,  5, 0, 0, 0, 512, 0, 0);
    for (int k = 0; k < 7; k++) add(0, 2, 0, 0, 0, 512, 0, 0);
    add(0,   2, 0, 0, 0, 512, 0, 1);
    add(0, -17, 0, 0, 0, 512, 0, 0);
    // Integrator ramp into output and integrator saturation
    add(1, 127, 0, 7, 0, 767, 0, 0);
    add(0, 127, 0, 7, 0, 1021, 0, 0);
    for (int k = 0; k < 8; k++) add(0, 127, 0, 7, 0, 1023, 1, 0);

    // Reset values
    do_reset(3);
    check("reset ctrl_o", int'(ctrl_o), 512);
    check("reset ctrl_valid_o", int'(ctrl_valid_o), 0);
    check("reset sat_o", int'(sat_o), 0);
    check("reset lock_o", int'(lock_o), 0);

    // Single sample latency: accept edge, then update strobe one edge later
    error_i = 8'sd10; kp_shift_i = 3'd6; ki_shift_i = 3'd0; error_valid_i = 1'b1;
    e.ctrl = 522; e.sat = 1'b0; e.idx = -1;
    sb.push_back(e);
    tick();
    error_valid_i = 1'b0;
    check("latency early valid", int'(ctrl_valid_o), 0);
    check("single lock_o", int'(lock_o), 0);
    tick();
    check("latency valid pulse", int'(ctrl_valid_o), 1);
    tick();
    check("valid one-cycle", int'(ctrl_valid_o), 0);
    check("ctrl_o hold", int'(ctrl_o), 522);

    // Table-driven back-to-back samples
    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        error_valid_i = 1'b0;
        drain();
        do_reset(2);
      end
      error_i       = 8'(tbl[i].err);
      kp_shift_i    = 3'(tbl[i].kp);
      ki_shift_i    = 3'(tbl[i].ki);
      freeze_i      = tbl[i].frz;
      error_valid_i = 1'b1;
      e.ctrl = tbl[i].ctrl; e.sat = tbl[i].sat; e.idx = i;
      sb.push_back(e);
      tick();
      check($sformatf("lock_o[%0d]", i), int'(lock_o), int'(tbl[i].lock));
    end
    error_valid_i = 1'b0;
    freeze_i      = 1'b0;
    drain();
    repeat (3) tick();
    check("saturated ctrl_o hold", int'(ctrl_o), 1023);
    check("saturated sat_o hold", int'(sat_o), 1);

    // Sample in flight is discarded by a reset on the following edge
    error_i = 8'sd100; kp_shift_i = 3'd6; ki_shift_i = 3'd0; error_valid_i = 1'b1;
    tick();
    error_valid_i = 1'b0;
    reset_i       = 1'b1;
    tick();
    reset_i = 1'b0;
    repeat (4) tick();
    check("flush ctrl_o", int'(ctrl_o), 512);
    check("flush ctrl_valid_o", int'(ctrl_valid_o), 0);
    check("flush sat_o", int'(sat_o), 0);
    check("flush lock_o", int'(lock_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
